// File: rtl/lu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lu_pkg
// Description : Shared opcode constants and FSM state encoding for the
//               bit-serial logic-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lu_pkg;

    // Bitwise opcodes understood by the 1-bit logic cell
    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_XNOR = 3'b110;
    localparam logic [2:0] OP_ANDN = 3'b111;

    // Sequencer states: wait for a grant, shift bits out, hold the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lu_state_t;

endpackage
`default_nettype wire

// File: rtl/lu_bit_cell.sv
`default_nettype none
// ============================================================================
// Module      : lu_bit_cell
// Description : Purely combinational 1-bit logic cell implementing the
//               eight-entry opcode table. b is ignored for OP_NOT.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_bit_cell
    import lu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] sel,
    output logic       s
);

    // Opcode decode for a single bit position
    always_comb begin
        s = 1'b0;
        case (sel)
            OP_NOT:  s = ~a;
            OP_AND:  s = a & b;
            OP_NAND: s = ~(a & b);
            OP_OR:   s = a | b;
            OP_NOR:  s = ~(a | b);
            OP_XOR:  s = a ^ b;
            OP_XNOR: s = ~(a ^ b);
            OP_ANDN: s = a & ~b;
            default: s = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lu_serial_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lu_serial_arbiter
// Description : Round-robin arbiter sharing one 1-bit logic cell between two
//               requesters. An accepted operation is evaluated LSB-first, one
//               bit per clock, and the assembled word is returned on a
//               valid/ready port tagged with the requester id.
// Options     : LU_SEQ_ZFLAG_EN - adds res_zero, high when the result is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lu_serial_arbiter
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
`ifdef LU_SEQ_ZFLAG_EN
    ,
    output logic             res_zero
`endif
);

    // Counter is one bit wider than an index so WIDTH=1 still has a register
    localparam int               c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    lu_state_t          r_state;
    lu_state_t          w_state_next;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_sel;
    logic               r_id;
    logic               r_last_grant;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_bit;

    // Round-robin grant: a lone requester wins, on contention the one not
    // granted last time wins
    always_comb begin
        w_grant0 = req0_valid && (!req1_valid || r_last_grant);
        w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        res_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = req0_ready || req1_ready;

    // Select the operand bits addressed by the counter
    always_comb begin
        w_a_bit = 1'b0;
        w_b_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == c_cnt_w'(i)) begin
                w_a_bit = r_a[i];
                w_b_bit = r_b[i];
            end
        end
    end

    lu_bit_cell u_bit_cell (
        .a   (w_a_bit),
        .b   (w_b_bit),
        .sel (r_sel),
        .s   (w_bit)
    );

    // New bits enter at the MSB so the first computed bit ends up at the LSB
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_res_next = w_bit;
        end else begin : g_shift_wn
            assign w_res_next = {w_bit, r_res[WIDTH-1:1]};
        end
    endgenerate

    // Operand capture at the handshake and serial result accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sel        <= OP_NOT;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_res        <= '0;
        end else if (w_accept) begin
            r_a          <= req1_ready ? req1_a   : req0_a;
            r_b          <= req1_ready ? req1_b   : req0_b;
            r_sel        <= req1_ready ? req1_sel : req0_sel;
            r_id         <= req1_ready;
            r_last_grant <= req1_ready;
            r_cnt        <= '0;
        end else if (r_state == RUN) begin
            r_res <= w_res_next;
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign res_data = r_res;
    assign res_id   = r_id;

`ifdef LU_SEQ_ZFLAG_EN
    logic r_zacc;

    // OR together every computed bit; the result is zero when none was set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zacc <= 1'b0;
        end else if (w_accept) begin
            r_zacc <= 1'b0;
        end else if (r_state == RUN) begin
            r_zacc <= r_zacc | w_bit;
        end
    end

    assign res_zero = (r_state == DONE) && !r_zacc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lu_serial_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lu_serial_arbiter
// Description : Self-checking bench for lu_serial_arbiter. Results, grant
//               order and latency come from a behavioural model of the
//               opcode table and round-robin rule.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lu_serial_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [2:0]       req0_sel;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [2:0]       req1_sel;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             busy;
`ifdef LU_SEQ_ZFLAG_EN
    logic             res_zero;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_last = 1'b1;

    lu_serial_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
`ifdef LU_SEQ_ZFLAG_EN
        ,
        .res_zero   (res_zero)
`endif
    );

    always #5 clk = ~clk;

    // Word-level reference for the opcode table
    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] sel,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (sel)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return ~(a & b);
            3'd3: return a | b;
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a & ~b;
        endcase
    endfunction

    // Offer one or two requests, check grant, latency, result and backpressure
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic [2:0] s0,
                           input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic [2:0] s1,
                           input int stall);
        bit               win;
        logic [WIDTH-1:0] expv;
        logic [WIDTH-1:0] held_data;
        logic             held_id;
        int               n;
        int               leaks;
        int               unstable;
        win  = (v0 && v1) ? ~exp_last : v1;
        expv = win ? ref_op(s1, a1, b1) : ref_op(s0, a0, b0);
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
        res_ready  = (stall == 0);
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        n_checks++;
        if ({req1_ready, req0_ready} !== (win ? 2'b10 : 2'b01))
            $display("FAIL grant: ready={%b,%b} expected winner %0d", req1_ready, req0_ready, win);
        else n_pass++;
        exp_last = win;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_sel = 3'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_sel = 3'($urandom);
        n = 0; leaks = 0;
        while (!res_valid && n < WIDTH + 6) begin
            if (req0_ready || req1_ready) leaks++;
            @(negedge clk); n++;
        end
        n_checks++;
        if (n !== WIDTH) $display("FAIL latency: got %0d edges expected %0d", n, WIDTH);
        else n_pass++;
        n_checks++;
        if (res_data !== expv) $display("FAIL res_data: got %h expected %h", res_data, expv);
        else n_pass++;
        n_checks++;
        if (res_id !== win) $display("FAIL res_id: got %b expected %b", res_id, win);
        else n_pass++;
`ifdef LU_SEQ_ZFLAG_EN
        n_checks++;
        if (res_zero !== (expv == '0)) $display("FAIL res_zero: got %b expected %b", res_zero, (expv == '0));
        else n_pass++;
`endif
        held_data = res_data; held_id = res_id; unstable = 0;
        for (int i = 0; i < stall; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            @(negedge clk); #1;
            if (res_data !== held_data || res_id !== held_id || res_valid !== 1'b1 || busy !== 1'b1) unstable++;
            if (req0_ready || req1_ready) leaks++;
        end
        if (stall > 0) begin
            n_checks++;
            if (unstable !== 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", unstable);
            else n_pass++;
        end
        n_checks++;
        if (leaks !== 0) $display("FAIL ready_leak: got %0d busy-cycle grants expected 0", leaks);
        else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({res_valid, busy} !== 2'b00) $display("FAIL complete: valid/busy=%b%b expected 00", res_valid, busy);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({res_valid, busy, res_id, req0_ready, req1_ready} !== 5'b0)
            $display("FAIL reset_ctl: got %b expected 00000", {res_valid, busy, res_id, req0_ready, req1_ready});
        else n_pass++;
        n_checks++;
        if (res_data !== '0) $display("FAIL reset_data: got %h expected 00", res_data);
        else n_pass++;
`ifdef LU_SEQ_ZFLAG_EN
        n_checks++;
        if (res_zero !== 1'b0) $display("FAIL reset_zero: got %b expected 0", res_zero);
        else n_pass++;
`endif
        reset = 1'b0;
        exp_last = 1'b1;
    endtask

    task automatic test_basic;
        run_txn(1'b1, 1'b0, 8'hA5, 8'h0F, 3'b001, 8'h00, 8'h00, 3'b000, 0);
    endtask

    task automatic test_req1_ops;
        run_txn(1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 8'hA5, 8'h3C, 3'b000, 0);
        run_txn(1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 8'hFF, 8'h0F, 3'b111, 0);
        run_txn(1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 8'hA5, 8'hA5, 3'b110, 0);
    endtask

    task automatic test_alternate;
        test_reset();
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), 3'($urandom), 0);
    endtask

    task automatic test_backpressure;
        run_txn(1'b1, 1'b0, 8'h5C, 8'h93, 3'b101, 8'h00, 8'h00, 3'b000, 5);
    endtask

    task automatic test_reset_mid;
        int n;
        int spurious;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34; req1_sel = 3'b011;
        res_ready = 1'b1;
        #1;
        n = 0;
        while (!req1_ready && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, res_valid, res_id} !== 3'b000) $display("FAIL mid_reset: busy/valid/id=%b expected 000", {busy, res_valid, res_id});
        else n_pass++;
        reset = 1'b0;
        exp_last = 1'b1;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid) spurious++;
        end
        n_checks++;
        if (spurious !== 0) $display("FAIL mid_reset_valid: got %0d valid cycles expected 0", spurious);
        else n_pass++;
        run_txn(1'b1, 1'b0, 8'h3C, 8'hC3, 3'b101, 8'h00, 8'h00, 3'b000, 0);
    endtask

    task automatic test_zflag;
        run_txn(1'b1, 1'b0, 8'hF0, 8'h0F, 3'b001, 8'h00, 8'h00, 3'b000, 0);
        run_txn(1'b1, 1'b0, 8'hF0, 8'h0F, 3'b011, 8'h00, 8'h00, 3'b000, 0);
    endtask

    task automatic test_random;
        bit v0;
        bit v1;
        for (int i = 0; i < 25; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_txn(v0, v1, 8'($urandom), 8'($urandom), 3'($urandom),
                    8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req1_ops();
        test_alternate();
        test_backpressure();
        test_reset_mid();
        test_zflag();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
